// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts between pipeline
// stages, ALU and divide opcode indices, memory access size codes, the
// divider state encoding and the combinational ALU.
package ex_stage_pkg;

  // One-hot ALU opcode bit positions
  localparam int ALU_OP_W = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // One-hot divide opcode bit positions
  localparam int DIV_OP_W = 4;
  localparam int DIV_W    = 0;
  localparam int MOD_W    = 1;
  localparam int DIV_WU   = 2;
  localparam int MOD_WU   = 3;

  // Memory access size codes
  localparam logic [1:0] MEM_SIZE_B = 2'b01;
  localparam logic [1:0] MEM_SIZE_H = 2'b10;
  localparam logic [1:0] MEM_SIZE_W = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Decode -> execute
  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DIV_OP_W-1:0] div_op;
    logic [31:0]         alu_src1;
    logic [31:0]         alu_src2;
    logic [31:0]         rj_value;
    logic [31:0]         rkd_value;
    logic [31:0]         simm;
    logic [4:0]          dest;
    logic                gr_we;
    logic                mem_load;
    logic                mem_store;
    logic [1:0]          mem_size;
    logic                mem_sign;     // 0 = sign-extend load data
    logic                csr_re;
    logic                csr_we;
    logic                csr_rw;
    logic [13:0]         csr_num;
    logic [31:0]         csr_wmask;
    logic                rdcnt_en;
    logic [2:0]          rdcnt_detail;
    logic                adef;
    logic                ine;
    logic                sys;
    logic                brk;
    logic                ertn;
  } ds_to_es_t;

  // Execute -> memory, in the order the MEM stage unpacks it
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_addr;
    logic        ale;
    logic        csr_re;
    logic        csr_we;
    logic        csr_rw;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rdcnt_en;
    logic [2:0]  rdcnt_detail;
    logic        adef;
    logic        ine;
    logic        sys;
    logic        brk;
    logic        ertn;
  } es_to_ms_t;

  // Execute -> decode forwarding
  typedef struct packed {
    logic        reg_able;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_we;
    logic        csr_rw;
  } es_to_ds_t;

  localparam int DS_TO_ES_BUS_WD = $bits(ds_to_es_t);
  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int ES_TO_DS_BUS_WD = $bits(es_to_ds_t);

  // Single-cycle ALU shared by the pipeline; op is one-hot so results are ORed.
  function automatic logic [31:0] alu_calc(input logic [ALU_OP_W-1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sra_res;
    logic [31:0] res;
    sa      = a;
    sb      = b;
    sra_res = sa >>> b[4:0];
    res     = '0;
    if (op[ALU_ADD])  res = res | (a + b);
    if (op[ALU_SUB])  res = res | (a - b);
    if (op[ALU_SLT])  res = res | {31'd0, sa < sb};
    if (op[ALU_SLTU]) res = res | {31'd0, a < b};
    if (op[ALU_AND])  res = res | (a & b);
    if (op[ALU_NOR])  res = res | ~(a | b);
    if (op[ALU_OR])   res = res | (a | b);
    if (op[ALU_XOR])  res = res | (a ^ b);
    if (op[ALU_SLL])  res = res | (a << b[4:0]);
    if (op[ALU_SRL])  res = res | (a >> b[4:0]);
    if (op[ALU_SRA])  res = res | sra_res;
    if (op[ALU_LUI])  res = res | b;
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk/reset (async, active-high); start launches a divide of x by y
// (is_signed selects signed semantics); flush aborts; ack releases DONE.
// busy/done expose the FSM; quotient/remainder hold the sign-corrected result
// while done is high. Divisor 0 yields quotient all-ones, remainder = x.
module divider
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        flush,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state, state_nxt;
  logic [5:0]  cnt;
  logic        load;
  logic signed [31:0] x_s;
  logic signed [31:0] y_s;
  logic [31:0] x_abs, y_abs;
  logic [31:0] quo_p0, rem_p0, dvs_p0;
  logic        neg_q_p0, neg_r_p0;
  logic [32:0] trial;
  logic [31:0] rem_sub;
  logic        fits;

  assign x_s   = x;
  assign y_s   = y;
  assign x_abs = (is_signed && x_s < 0) ? 32'd0 - x : x;
  assign y_abs = (is_signed && y_s < 0) ? 32'd0 - y : y;
  assign load  = (state == DIV_IDLE) && start && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start && !flush) state_nxt = DIV_BUSY;
      DIV_BUSY: begin
        if (flush)              state_nxt = DIV_IDLE;
        else if (cnt == 6'd31)  state_nxt = DIV_DONE;
      end
      DIV_DONE: if (flush || ack) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= '0;
    else if (state == DIV_BUSY) cnt <= cnt + 6'd1;
  end

  // Shift the next dividend bit into the partial remainder and subtract the
  // divisor when it fits. With a zero divisor every step "fits", which leaves
  // an all-ones quotient and the dividend magnitude as remainder.
  assign trial   = {rem_p0, quo_p0[31]};
  assign fits    = trial >= {1'b0, dvs_p0};
  assign rem_sub = trial[31:0] - dvs_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_p0 <= '0;
      rem_p0 <= '0;
    end else if (load) begin
      quo_p0 <= x_abs;
      rem_p0 <= '0;
    end else if (state == DIV_BUSY) begin
      quo_p0 <= {quo_p0[30:0], fits};
      rem_p0 <= fits ? rem_sub : trial[31:0];
    end
  end

  // Quotient is negated only for a real signed divide with differing signs;
  // skipping it for y == 0 keeps the all-ones quotient.
  always_ff @(posedge clk) begin
    if (load) begin
      dvs_p0   <= y_abs;
      neg_q_p0 <= is_signed && (x[31] ^ y[31]) && (y != 32'd0);
      neg_r_p0 <= is_signed && x[31];
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q_p0 ? 32'd0 - quo_p0 : quo_p0;
  assign remainder = neg_r_p0 ? 32'd0 - rem_p0 : rem_p0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the in-order pipeline.
// Ports: clk, reset (async, active-high); ds_to_es_valid/ds_to_es_bus from
// decode; es_allowin back-pressure to decode; ms_allowin, es_to_ms_valid and
// es_to_ms_bus toward memory; data_sram_* drive the data RAM request;
// es_to_ds_bus forwards result/dest to decode; ws_ertn_flush/ws_ex_flush
// flush the stage from writeback.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  input  logic                       ws_ertn_flush,
  input  logic                       ws_ex_flush
);

  ds_to_es_t   es_bus_p0;
  logic        es_valid;
  logic        flush;
  logic        es_ready_go;
  logic        is_div, div_signed, div_start, div_ack, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [31:0] alu_result, es_result, mem_addr;
  logic        mem_op, ale, exc_carried;
  logic [3:0]  st_mask;
  es_to_ms_t   ms_bus;
  es_to_ds_t   ds_bus;

  assign flush = ws_ertn_flush | ws_ex_flush;

  // ---- Stage register: decode -> execute ----
  // Flush wins over a simultaneous new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           es_valid <= 1'b0;
    else if (flush)      es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             es_bus_p0 <= '0;
    else if (ds_to_es_valid && es_allowin) es_bus_p0 <= ds_to_es_bus;
  end

  // ---- Execute ----
  assign is_div      = |es_bus_p0.div_op;
  assign div_signed  = es_bus_p0.div_op[DIV_W] | es_bus_p0.div_op[MOD_W];
  assign es_ready_go = !is_div || div_done;
  assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  // Launch only from IDLE so a completed result is not recomputed.
  assign div_start = es_valid && is_div && !div_busy && !div_done;
  assign div_ack   = es_valid && es_ready_go && ms_allowin;

  divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .is_signed (div_signed),
    .x         (es_bus_p0.alu_src1),
    .y         (es_bus_p0.alu_src2),
    .flush     (flush),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign alu_result = alu_calc(es_bus_p0.alu_op, es_bus_p0.alu_src1, es_bus_p0.alu_src2);
  assign es_result  = !is_div ? alu_result :
                      (es_bus_p0.div_op[DIV_W] | es_bus_p0.div_op[DIV_WU]) ? div_q : div_r;

  assign mem_addr    = es_bus_p0.rj_value + es_bus_p0.simm;
  assign mem_op      = es_bus_p0.mem_load | es_bus_p0.mem_store;
  assign exc_carried = es_bus_p0.adef | es_bus_p0.ine | es_bus_p0.sys | es_bus_p0.brk;

  always_comb begin
    ale     = 1'b0;
    st_mask = 4'b0000;
    data_sram_wdata = es_bus_p0.rkd_value;
    case (es_bus_p0.mem_size)
      MEM_SIZE_B: begin
        st_mask         = 4'b0001 << mem_addr[1:0];
        data_sram_wdata = {4{es_bus_p0.rkd_value[7:0]}};
      end
      MEM_SIZE_H: begin
        ale             = mem_op && mem_addr[0];
        st_mask         = 4'b0011 << mem_addr[1:0];
        data_sram_wdata = {2{es_bus_p0.rkd_value[15:0]}};
      end
      MEM_SIZE_W: begin
        ale     = mem_op && (mem_addr[1:0] != 2'b00);
        st_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // The request fires only in the cycle the instruction actually leaves.
  assign data_sram_en   = es_valid && mem_op && !exc_carried && !ale && !flush &&
                          es_ready_go && ms_allowin;
  assign data_sram_we   = (data_sram_en && es_bus_p0.mem_store) ? st_mask : 4'b0000;
  assign data_sram_addr = {mem_addr[31:2], 2'b00};

  // ---- Output buses: execute -> memory, execute -> decode ----
  always_comb begin
    ms_bus              = '0;
    ms_bus.pc           = es_bus_p0.pc;
    ms_bus.result       = es_result;
    ms_bus.dest         = es_bus_p0.dest;
    ms_bus.gr_we        = es_bus_p0.gr_we;
    ms_bus.mem_load     = es_bus_p0.mem_load;
    ms_bus.mem_store    = es_bus_p0.mem_store;
    ms_bus.mem_size     = es_bus_p0.mem_size;
    ms_bus.mem_sign     = es_bus_p0.mem_sign;
    ms_bus.mem_addr     = mem_addr;
    ms_bus.ale          = ale;
    ms_bus.csr_re       = es_bus_p0.csr_re;
    ms_bus.csr_we       = es_bus_p0.csr_we;
    ms_bus.csr_rw       = es_bus_p0.csr_rw;
    ms_bus.csr_num      = es_bus_p0.csr_num;
    ms_bus.csr_wmask    = es_bus_p0.csr_wmask;
    ms_bus.csr_wvalue   = es_bus_p0.rkd_value;
    ms_bus.rdcnt_en     = es_bus_p0.rdcnt_en;
    ms_bus.rdcnt_detail = es_bus_p0.rdcnt_detail;
    ms_bus.adef         = es_bus_p0.adef;
    ms_bus.ine          = es_bus_p0.ine;
    ms_bus.sys          = es_bus_p0.sys;
    ms_bus.brk          = es_bus_p0.brk;
    ms_bus.ertn         = es_bus_p0.ertn;
  end

  // Results not yet known in this stage cannot be forwarded.
  always_comb begin
    ds_bus          = '0;
    ds_bus.reg_able = !(es_valid && (es_bus_p0.mem_load || es_bus_p0.csr_re ||
                                     es_bus_p0.rdcnt_en || (is_div && !div_done)));
    ds_bus.dest     = es_bus_p0.dest & {5{es_valid}};
    ds_bus.result   = es_result;
    ds_bus.csr_we   = es_bus_p0.csr_we;
    ds_bus.csr_rw   = es_bus_p0.csr_rw;
  end

  assign es_to_ms_bus = ms_bus;
  assign es_to_ds_bus = ds_bus;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle instructions plus
// hand-written sequences for divides, flushes, stalls and reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_we;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;
  logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus;
  logic                       ws_ertn_flush;
  logic                       ws_ex_flush;

  es_to_ms_t ms_view;
  es_to_ds_t ds_view;
  assign ms_view = es_to_ms_bus;
  assign ds_view = es_to_ds_bus;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_to_ds_bus    (es_to_ds_bus),
    .ws_ertn_flush   (ws_ertn_flush),
    .ws_ex_flush     (ws_ex_flush)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic ds_to_es_t alu_ins(input int op, input logic [31:0] a, input logic [31:0] b);
    ds_to_es_t d;
    d = '0;
    d.pc = 32'h1c00_0000;
    d.alu_op[op] = 1'b1;
    d.alu_src1 = a;
    d.alu_src2 = b;
    d.dest = 5'd9;
    d.gr_we = 1'b1;
    return d;
  endfunction

  function automatic ds_to_es_t div_ins(input int op, input logic [31:0] a, input logic [31:0] b);
    ds_to_es_t d;
    d = '0;
    d.div_op[op] = 1'b1;
    d.alu_src1 = a;
    d.alu_src2 = b;
    d.dest = 5'd9;
    d.gr_we = 1'b1;
    return d;
  endfunction

  function automatic ds_to_es_t mem_ins(input logic ld, input logic st, input logic [1:0] size,
                                        input logic [31:0] rj, input logic [31:0] simm,
                                        input logic [31:0] rkd, input logic ine);
    ds_to_es_t d;
    d = '0;
    d.mem_load = ld;
    d.mem_store = st;
    d.mem_size = size;
    d.rj_value = rj;
    d.simm = simm;
    d.rkd_value = rkd;
    d.ine = ine;
    d.dest = 5'd4;
    d.gr_we = ld;
    return d;
  endfunction

  typedef struct {
    ds_to_es_t   ins;
    logic [31:0] result;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ale;
    logic        reg_able;
  } vec_t;

  function automatic vec_t mk(input ds_to_es_t ins, input logic [31:0] result, input logic en,
                              input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ale, input logic reg_able);
    vec_t v;
    v.ins = ins; v.result = result; v.en = en; v.we = we;
    v.addr = addr; v.wdata = wdata; v.ale = ale; v.reg_able = reg_able;
    return v;
  endfunction

  vec_t vecs[13];

  // Drive one instruction for one cycle; returns #1 after its entry edge.
  task automatic send(input ds_to_es_t ins);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = ins;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
  endtask

  // Count residence cycles until es_to_ms_valid; n = 0 on timeout.
  task automatic wait_out(input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (es_to_ms_valid) begin
        n = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic div_seq(input string name, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    send(div_ins(op, a, b));
    wait_out(60, n);
    check({name, "_cycles"}, 32'(n), 32'd34);
    if (n != 0) begin
      check({name, "_result"}, ms_view.result, exp);
      check({name, "_reg_able"}, 32'(ds_view.reg_able), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [ES_TO_MS_BUS_WD-1:0] snap;

    vecs[0]  = mk(alu_ins(ALU_ADD, 32'd3, 32'd4),                 32'd7,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[1]  = mk(alu_ins(ALU_SUB, 32'd3, 32'd4),                 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[2]  = mk(alu_ins(ALU_SLT, 32'hFFFFFFFF, 32'd1),          32'd1,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[3]  = mk(alu_ins(ALU_SLTU, 32'hFFFFFFFF, 32'd1),         32'd0,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[4]  = mk(alu_ins(ALU_SRA, 32'h80000000, 32'd4),          32'hF8000000, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[5]  = mk(alu_ins(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00),   32'h0FF00FF0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    vecs[6]  = mk(mem_ins(1, 0, MEM_SIZE_W, 32'h1000, 32'd4, 32'h0, 0),
                  32'd0, 1'b1, 4'b0000, 32'h1004, 32'h0, 1'b0, 1'b0);
    vecs[7]  = mk(mem_ins(0, 1, MEM_SIZE_B, 32'h1000, 32'd2, 32'h123456AB, 0),
                  32'd0, 1'b1, 4'b0100, 32'h1000, 32'hABABABAB, 1'b0, 1'b1);
    vecs[8]  = mk(mem_ins(0, 1, MEM_SIZE_H, 32'h1000, 32'd2, 32'h00001234, 0),
                  32'd0, 1'b1, 4'b1100, 32'h1000, 32'h12341234, 1'b0, 1'b1);
    vecs[9]  = mk(mem_ins(0, 1, MEM_SIZE_W, 32'h1000, 32'd2, 32'hDEADBEEF, 0),
                  32'd0, 1'b0, 4'b0000, 32'h1000, 32'hDEADBEEF, 1'b1, 1'b1);
    vecs[10] = mk(mem_ins(1, 0, MEM_SIZE_H, 32'h1000, 32'd1, 32'h0, 0),
                  32'd0, 1'b0, 4'b0000, 32'h1000, 32'h0, 1'b1, 1'b0);
    vecs[11] = mk(mem_ins(0, 1, MEM_SIZE_W, 32'h2000, 32'hFFFFFFFC, 32'hCAFEF00D, 1),
                  32'd0, 1'b0, 4'b0000, 32'h1FFC, 32'hCAFEF00D, 1'b0, 1'b1);
    vecs[12] = mk(mem_ins(1, 0, MEM_SIZE_B, 32'h1003, 32'd0, 32'h0, 0),
                  32'd0, 1'b1, 4'b0000, 32'h1000, 32'h0, 1'b0, 1'b0);

    reset = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    ms_allowin = 1'b1; ws_ertn_flush = 1'b0; ws_ex_flush = 1'b0;
    #2 reset = 1'b1;
    #5;
    check("rst_allowin",  32'(es_allowin),     32'd1);
    check("rst_to_ms",    32'(es_to_ms_valid), 32'd0);
    check("rst_en",       32'(data_sram_en),   32'd0);
    check("rst_we",       32'(data_sram_we),   32'd0);
    check("rst_fwd_dest", 32'(ds_view.dest),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_allowin", 32'(es_allowin),     32'd1);
    check("post_rst_to_ms",   32'(es_to_ms_valid), 32'd0);
    @(posedge clk); #1;

    // Single-cycle table
    foreach (vecs[i]) begin
      send(vecs[i].ins);
      @(negedge clk);
      check($sformatf("v%0d_to_ms", i),    32'(es_to_ms_valid),   32'd1);
      check($sformatf("v%0d_result", i),   ms_view.result,        vecs[i].result);
      check($sformatf("v%0d_en", i),       32'(data_sram_en),     32'(vecs[i].en));
      check($sformatf("v%0d_we", i),       32'(data_sram_we),     32'(vecs[i].we));
      check($sformatf("v%0d_addr", i),     data_sram_addr,        vecs[i].addr);
      check($sformatf("v%0d_wdata", i),    data_sram_wdata,       vecs[i].wdata);
      check($sformatf("v%0d_ale", i),      32'(ms_view.ale),      32'(vecs[i].ale));
      check($sformatf("v%0d_reg_able", i), 32'(ds_view.reg_able), 32'(vecs[i].reg_able));
      @(posedge clk); #1;
    end

    // Pass-through of csr / exception / counter fields
    begin
      ds_to_es_t d;
      d = alu_ins(ALU_OR, 32'h0, 32'h0);
      d.csr_re = 1'b1; d.csr_we = 1'b1; d.csr_num = 14'h123;
      d.rdcnt_detail = 3'b101; d.ine = 1'b1; d.brk = 1'b1;
      send(d);
      @(negedge clk);
      check("pass_fields", {ms_view.csr_num, 10'd0, ms_view.rdcnt_detail, ms_view.adef,
                            ms_view.ine, ms_view.sys, ms_view.brk, ms_view.ertn},
                           {14'h123, 10'd0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      check("pass_csr_we_fwd", 32'(ds_view.csr_we),   32'd1);
      check("csr_reg_able",    32'(ds_view.reg_able), 32'd0);
      @(posedge clk); #1;
    end

    // Divides
    div_seq("div_w_m7_2",   DIV_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    div_seq("mod_w_m7_2",   MOD_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    div_seq("div_w_7_m2",   DIV_W,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    div_seq("mod_w_7_m2",   MOD_W,  32'd7,        32'hFFFFFFFE, 32'd1);
    div_seq("div_wu_5_0",   DIV_WU, 32'd5,        32'd0,        32'hFFFFFFFF);
    div_seq("mod_wu_5_0",   MOD_WU, 32'd5,        32'd0,        32'd5);
    div_seq("div_w_m5_0",   DIV_W,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    div_seq("mod_w_m5_0",   MOD_W,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    div_seq("div_w_min_m1", DIV_W,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    div_seq("mod_w_min_m1", MOD_W,  32'h80000000, 32'hFFFFFFFF, 32'd0);
    div_seq("div_wu_big",   DIV_WU, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF);

    // Flush during BUSY cycle 10
    send(div_ins(DIV_W, 32'd100, 32'd7));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_allowin",  32'(es_allowin),       32'd0);
    check("busy_to_ms",    32'(es_to_ms_valid),   32'd0);
    check("busy_reg_able", 32'(ds_view.reg_able), 32'd0);
    check("busy_dest",     32'(ds_view.dest),     32'd9);
    repeat (6) @(posedge clk);
    #1;
    ws_ex_flush = 1'b1;
    @(posedge clk); #1;
    ws_ex_flush = 1'b0;
    @(negedge clk);
    check("flush_allowin", 32'(es_allowin),     32'd1);
    check("flush_to_ms",   32'(es_to_ms_valid), 32'd0);
    check("flush_dest",    32'(ds_view.dest),   32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (es_to_ms_valid) seen++;
    end
    check("flush_no_output", 32'(seen), 32'd0);
    @(posedge clk); #1;
    div_seq("after_flush_mod", MOD_W, 32'd100, 32'd7, 32'd2);

    // Stall: valid load held while ms_allowin is low
    ms_allowin = 1'b0;
    send(mem_ins(1, 0, MEM_SIZE_W, 32'h3000, 32'd8, 32'h0, 0));
    @(negedge clk);
    snap = es_to_ms_bus;
    check("stall_en",      32'(data_sram_en),   32'd0);
    check("stall_to_ms",   32'(es_to_ms_valid), 32'd1);
    check("stall_allowin", 32'(es_allowin),     32'd0);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = alu_ins(ALU_ADD, 32'd1, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall_bus_c%0d", c), 32'(es_to_ms_bus == snap), 32'd1);
      check($sformatf("stall_en_c%0d", c),  32'(data_sram_en),         32'd0);
    end
    #1;
    ms_allowin = 1'b1;
    #1;
    check("release_en",   32'(data_sram_en), 32'd1);
    check("release_addr", data_sram_addr,    32'h3008);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    @(negedge clk);
    check("next_to_ms",   32'(es_to_ms_valid), 32'd1);
    check("next_result",  ms_view.result,      32'd2);
    @(posedge clk); #1;

    // Flush in the same cycle suppresses the memory request
    send(mem_ins(1, 0, MEM_SIZE_W, 32'h4000, 32'd0, 32'h0, 0));
    ws_ertn_flush = 1'b1;
    @(negedge clk);
    check("ertn_flush_en", 32'(data_sram_en), 32'd0);
    @(posedge clk); #1;
    ws_ertn_flush = 1'b0;
    @(negedge clk);
    check("ertn_flush_to_ms", 32'(es_to_ms_valid), 32'd0);
    @(posedge clk); #1;

    // Flush beats a simultaneous entry
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = alu_ins(ALU_ADD, 32'd2, 32'd2);
    ws_ex_flush    = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ws_ex_flush    = 1'b0;
    @(negedge clk);
    check("prio_to_ms",   32'(es_to_ms_valid), 32'd0);
    check("prio_allowin", 32'(es_allowin),     32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    send(div_ins(DIV_WU, 32'd50, 32'd5));
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_allowin", 32'(es_allowin),     32'd1);
    check("mid_rst_to_ms",   32'(es_to_ms_valid), 32'd0);
    check("mid_rst_we",      32'(data_sram_we),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    div_seq("after_rst_div", DIV_WU, 32'd50, 32'd5, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
